// File: rtl/nibble_serial_sub_ctrl_if.sv
// Request/response handshake plus the 4-bit slice hookup for nibble_serial_sub_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface nibble_serial_sub_ctrl_if #(parameter int WIDTH = 16);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Zero;
  logic [3:0]       fs_A;
  logic [3:0]       fs_B;
  logic             fs_Bin;
  logic [3:0]       fs_Diff;
  logic             fs_Bout;

  modport slave (
    input  start_valid, A, B, Bin, result_ready, fs_Diff, fs_Bout,
    output start_ready, result_valid, Diff, Bout, Zero, fs_A, fs_B, fs_Bin
  );

  modport master (
    output start_valid, A, B, Bin, result_ready, fs_Diff, fs_Bout,
    input  start_ready, result_valid, Diff, Bout, Zero, fs_A, fs_B, fs_Bin
  );
endinterface

// File: rtl/nibble_serial_sub_ctrl.sv
// Runs A - B - Bin through one external 4-bit subtractor slice, one nibble per cycle,
// LSB first, carrying the borrow in a register between nibbles.
module nibble_serial_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_sub_ctrl_if.slave  bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             start_ready;
  logic [3:0]       fs_a, fs_b;
  logic             fs_bin;
  logic [WIDTH-1:0] diff_upd;

  // Held low during reset so nothing upstream believes a request was taken.
  assign start_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    fs_a     = 4'd0;
    fs_b     = 4'd0;
    fs_bin   = 1'b0;

    // Result as it stands once the current nibble lands; Zero needs it on the last edge.
    diff_upd = diff_q;
    diff_upd[4*idx_q +: 4] = bus.fs_Diff;

    case (state_q)
      S_IDLE: begin
        if (bus.start_valid && start_ready) begin
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.Bin;
          idx_d    = '0;
          diff_d   = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        fs_a     = a_q[4*idx_q +: 4];
        fs_b     = b_q[4*idx_q +: 4];
        fs_bin   = borrow_q;
        diff_d   = diff_upd;
        borrow_d = bus.fs_Bout;
        if (idx_q == LAST_IDX) begin
          bout_d  = bus.fs_Bout;
          zero_d  = (diff_upd == '0);
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.start_ready  = start_ready;
  assign bus.result_valid = (state_q == S_DONE);
  assign bus.Diff         = diff_q;
  assign bus.Bout         = bout_q;
  assign bus.Zero         = zero_q;
  assign bus.fs_A         = fs_a;
  assign bus.fs_B         = fs_b;
  assign bus.fs_Bin       = fs_bin;
endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Bench for nibble_serial_sub_ctrl at WIDTH=16 with a behavioural 4-bit subtractor slice.
module tb_nibble_serial_sub_ctrl;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  nibble_serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  nibble_serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Slice: 5-bit subtraction, bit 4 is the borrow out.
  logic [4:0] slice_t;
  assign slice_t = {1'b0, bus_if.fs_A} - {1'b0, bus_if.fs_B} - {4'd0, bus_if.fs_Bin};
  assign bus_if.fs_Diff = slice_t[3:0];
  assign bus_if.fs_Bout = slice_t[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        z;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Borrow entering nibble n: whether the low 4n bits of A are below those of B plus Bin.
  function automatic logic borrow_into(input logic [15:0] a, input logic [15:0] b,
                                       input logic bin, input int n);
    longint mask;
    mask = (longint'(1) << (4 * n)) - 1;
    return (longint'(a) & mask) < ((longint'(b) & mask) + longint'(bin));
  endfunction

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input string tag);
    chk({tag, "_start_ready"}, 32'(bus_if.start_ready), 32'd1);
    chk({tag, "_fs_idle"}, {23'd0, bus_if.fs_A, bus_if.fs_B, bus_if.fs_Bin}, 32'd0);
    bus_if.start_valid = 1'b1;
    bus_if.A = a;
    bus_if.B = b;
    bus_if.Bin = bin;
    tick();
    bus_if.start_valid = 1'b0;
    bus_if.A = 16'($urandom);
    bus_if.B = 16'($urandom);
    bus_if.Bin = 1'($urandom);
  endtask

  task automatic wait_check(input logic [15:0] a, input logic [15:0] b, input logic bin,
                            input logic [15:0] ed, input logic eb, input logic ez,
                            input string tag);
    int n;
    n = 0;
    while (!bus_if.result_valid && n < 20) begin
      if (n < NIBBLES) begin
        chk({tag, "_fs_A"}, 32'(bus_if.fs_A), 32'(a[4*n +: 4]));
        chk({tag, "_fs_B"}, 32'(bus_if.fs_B), 32'(b[4*n +: 4]));
        chk({tag, "_fs_Bin"}, 32'(bus_if.fs_Bin), 32'(borrow_into(a, b, bin, n)));
      end
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(NIBBLES));
    chk({tag, "_diff"}, 32'(bus_if.Diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bus_if.Bout), 32'(eb));
    chk({tag, "_zero"}, 32'(bus_if.Zero), 32'(ez));
    chk({tag, "_busy"}, 32'(bus_if.start_ready), 32'd0);
  endtask

  task automatic release_result(input logic [15:0] ed, input string tag);
    bus_if.result_ready = 1'b1;
    tick();
    bus_if.result_ready = 1'b0;
    chk({tag, "_rv_drop"}, 32'(bus_if.result_valid), 32'd0);
    chk({tag, "_diff_held"}, 32'(bus_if.Diff), 32'(ed));
  endtask

  initial begin
    logic [16:0] ref_v;
    logic [15:0] ra, rb;
    logic        rbin;
    int          prev_acc, k, rose;

    total = 0;
    bad   = 0;
    vecs[0] = '{a:16'h1234, b:16'h0234, bin:1'b0, d:16'h1000, bo:1'b0, z:1'b0};
    vecs[1] = '{a:16'h0000, b:16'h0001, bin:1'b0, d:16'hFFFF, bo:1'b1, z:1'b0};
    vecs[2] = '{a:16'h0005, b:16'h0005, bin:1'b1, d:16'hFFFF, bo:1'b1, z:1'b0};
    vecs[3] = '{a:16'h0005, b:16'h0005, bin:1'b0, d:16'h0000, bo:1'b0, z:1'b1};
    vecs[4] = '{a:16'hFFFF, b:16'hFFFF, bin:1'b1, d:16'hFFFF, bo:1'b1, z:1'b0};
    vecs[5] = '{a:16'h8000, b:16'h0001, bin:1'b0, d:16'h7FFF, bo:1'b0, z:1'b0};
    vecs[6] = '{a:16'hFFFF, b:16'h0000, bin:1'b1, d:16'hFFFE, bo:1'b0, z:1'b0};

    rst = 1'b1;
    bus_if.start_valid  = 1'b0;
    bus_if.result_ready = 1'b0;
    bus_if.A   = '0;
    bus_if.B   = '0;
    bus_if.Bin = 1'b0;
    tick();
    tick();
    chk("rst_result_valid", 32'(bus_if.result_valid), 32'd0);
    chk("rst_start_ready", 32'(bus_if.start_ready), 32'd0);
    chk("rst_outputs", {15'd0, bus_if.Diff, bus_if.Bout, bus_if.Zero}, 32'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      accept(vecs[i].a, vecs[i].b, vecs[i].bin, tag);
      wait_check(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].z, tag);
      release_result(vecs[i].d, tag);
    end

    // Backpressure in DONE with a competing request pending.
    accept(16'h00F0, 16'h000F, 1'b0, "bp");
    wait_check(16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0, "bp");
    bus_if.start_valid = 1'b1;
    bus_if.A   = 16'h1111;
    bus_if.B   = 16'h0001;
    bus_if.Bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_rv", 32'(bus_if.result_valid), 32'd1);
      chk("bp_hold_ready", 32'(bus_if.start_ready), 32'd0);
      chk("bp_hold_diff", 32'(bus_if.Diff), 32'h00E1);
      chk("bp_hold_bout", 32'(bus_if.Bout), 32'd0);
    end
    bus_if.result_ready = 1'b1;
    tick();
    bus_if.result_ready = 1'b0;
    chk("bp_idle_ready", 32'(bus_if.start_ready), 32'd1);
    chk("bp_idle_rv", 32'(bus_if.result_valid), 32'd0);
    tick();
    bus_if.start_valid = 1'b0;
    wait_check(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0, "bp_next");
    release_result(16'h1110, "bp_next");

    // Reset in the middle of a run.
    accept(16'h8000, 16'h0001, 1'b0, "mid_rst");
    tick();
    tick();
    chk("mid_rst_fs_A_idx2", 32'(bus_if.fs_A), 32'd0);
    chk("mid_rst_fs_Bin_idx2", 32'(bus_if.fs_Bin), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_rv", 32'(bus_if.result_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus_if.start_ready), 32'd0);
    chk("mid_rst_outputs", {15'd0, bus_if.Diff, bus_if.Bout, bus_if.Zero}, 32'd0);
    chk("mid_rst_fs", {23'd0, bus_if.fs_A, bus_if.fs_B, bus_if.fs_Bin}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", 32'(bus_if.start_ready), 32'd1);
    rose = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_if.result_valid) rose++;
    end
    chk("mid_rst_no_result", 32'(rose), 32'd0);
    accept(16'h0010, 16'h0001, 1'b0, "post_rst");
    wait_check(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, "post_rst");
    release_result(16'h000F, "post_rst");

    // Back-to-back random ops against A - B - Bin computed at 17 bits.
    bus_if.result_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 20; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (i % 5 == 0) begin
        rb   = ra;
        rbin = 1'b0;
      end
      ref_v = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
      bus_if.start_valid = 1'b1;
      bus_if.A   = ra;
      bus_if.B   = rb;
      bus_if.Bin = rbin;
      k = 0;
      while (!bus_if.start_ready && k < 20) begin
        tick();
        k++;
      end
      if (k >= 20) chk("rnd_ready_timeout", 32'(k), 32'd0);
      tick();
      bus_if.start_valid = 1'b0;
      if (i > 0) chk("rnd_spacing", 32'(cyc - prev_acc), 32'(NIBBLES + 2));
      prev_acc = cyc;
      wait_check(ra, rb, rbin, ref_v[15:0], ref_v[16], (ref_v[15:0] == 16'd0), "rnd");
    end
    tick();
    bus_if.result_ready = 1'b0;
    chk("rnd_end_idle", 32'(bus_if.start_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
